// File: rtl/fifo_rd_packer_pkg.sv
// fifo_rd_packer_pkg: shared state encodings, word geometry and byte-enable helper
//   Imported by fifo_rd_packer and fifo_rd_packer_tmo.
package fifo_rd_packer_pkg;
  typedef enum logic [1:0] {HDR = 2'd0, PAY = 2'd1, ABORT = 2'd2} state_e;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  // n low bytes enabled, n = 0..4
  function automatic logic [LANES-1:0] be_of(input logic [2:0] n);
    be_of = LANES'((5'd1 << n) - 5'd1);
  endfunction
endpackage

// File: rtl/fifo_rd_packer_tmo.sv
// fifo_rd_packer_tmo: saturating empty-cycle counter for the mid-packet timeout
//   clk_rd/rst_rd_n : clock, async active-low reset
//   i_clr           : clear counter (pop or not in payload)
//   i_en            : count this cycle (FIFO empty)
//   o_expired       : counter has reached LIMIT-1
module fifo_rd_packer_tmo
  import fifo_rd_packer_pkg::*;
#(
  parameter int LIMIT = 64,
  parameter int W     = 7
) (
  input  logic clk_rd,
  input  logic rst_rd_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [W-1:0] tmo_q, tmo_d;
  assign o_expired = tmo_q == W'(LIMIT - 1);
  always_comb tmo_d = i_clr ? '0 : (i_en && !o_expired) ? tmo_q + 1'b1 : tmo_q;
  always_ff @(posedge clk_rd or negedge rst_rd_n)
    if (!rst_rd_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: repacks a length-framed byte stream from a FWFT FIFO into 32-bit words
//   clk_rd, rst_rd_n           : read-domain clock, async active-low reset
//   i_fifo_data, i_fifo_empty  : FIFO head byte and empty flag
//   o_fifo_rd_en               : pop FIFO head at the clock edge
//   o_valid/i_ready            : output handshake
//   o_data, o_be, o_last, o_err: packed word (first byte in [7:0]), byte enables, end of packet, truncated
//   Optional: FIFO_RD_PACKER_TIMEOUT_EN adds the mid-packet timeout and ABORT state.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TMO_W       = 7
) (
  input  logic              clk_rd,
  input  logic              rst_rd_n,
  input  logic [7:0]        i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic [LANES-1:0]  o_be,
  output logic              o_last,
  output logic              o_err
);
  if (2 ** TMO_W <= TIMEOUT_CYC) begin : g_bad_tmo_w
    $error("TMO_W too narrow for TIMEOUT_CYC");
  end
  state_e state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [1:0] cnt_q, cnt_d;
  logic [23:0] acc_q, acc_d;
  logic valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic [WORD_W-1:0] data_q, data_d, merged;
  logic [LANES-1:0] be_q, be_d;
  logic out_free, completing, rd_en, tmo_expired;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  fifo_rd_packer_tmo #(.LIMIT(TIMEOUT_CYC), .W(TMO_W)) u_tmo (
    .clk_rd    (clk_rd),
    .rst_rd_n  (rst_rd_n),
    .i_clr     (state_q != PAY || rd_en),
    .i_en      (i_fifo_empty),
    .o_expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif
  assign out_free   = !valid_q || i_ready;
  assign completing = cnt_q == 2'd3 || rem_q == 8'd1;
  // only the completing byte waits for the output register
  assign rd_en      = !i_fifo_empty && (state_q == HDR || (state_q == PAY && (!completing || out_free)));
  // acc bytes at and above cnt are always zero, so OR-merging keeps unused lanes clear
  assign merged     = {8'h00, acc_q} | ({24'h0, i_fifo_data} << {cnt_q, 3'b000});
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valid_d = valid_q && !i_ready;
    data_d  = data_q;
    be_d    = be_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      HDR: if (rd_en) begin
        rem_d   = i_fifo_data;
        state_d = i_fifo_data == 8'h00 ? HDR : PAY;
      end
      PAY: if (rd_en) begin
        rem_d = rem_q - 8'd1;
        if (completing) begin
          valid_d = 1'b1;
          data_d  = merged;
          be_d    = be_of({1'b0, cnt_q} + 3'd1);
          last_d  = rem_q == 8'd1;
          err_d   = 1'b0;
          cnt_d   = 2'd0;
          acc_d   = '0;
          state_d = rem_q == 8'd1 ? HDR : PAY;
        end else begin
          acc_d = merged[23:0];
          cnt_d = cnt_q + 2'd1;
        end
      end else if (i_fifo_empty && tmo_expired) state_d = ABORT;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
      ABORT: if (out_free) begin
        valid_d = 1'b1;
        data_d  = {8'h00, acc_q};
        be_d    = be_of({1'b0, cnt_q});
        last_d  = 1'b1;
        err_d   = 1'b1;
        cnt_d   = 2'd0;
        acc_d   = '0;
        rem_d   = 8'd0;
        state_d = HDR;
      end
`endif
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge clk_rd or negedge rst_rd_n)
    if (!rst_rd_n) begin
      state_q <= HDR;
      rem_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      be_q    <= be_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  assign o_fifo_rd_en = rd_en;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_be         = be_q;
  assign o_last       = last_q;
  assign o_err        = err_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  localparam int TCYC = 4;
`else
  localparam int TCYC = 64;
`endif
  logic clk_rd = 1'b0, rst_rd_n = 1'b0;
  logic [7:0] i_fifo_data = 8'h00;
  logic i_fifo_empty = 1'b1, i_ready = 1'b0;
  logic o_fifo_rd_en, o_valid, o_last, o_err;
  logic [31:0] o_data;
  logic [3:0] o_be;
  fifo_rd_packer #(.TIMEOUT_CYC(TCYC), .TMO_W(7)) dut (
    .clk_rd       (clk_rd),
    .rst_rd_n     (rst_rd_n),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_be         (o_be),
    .o_last       (o_last),
    .o_err        (o_err)
  );
  always #5 clk_rd = ~clk_rd;
  logic [7:0] fq[$];
  int pop_cyc[$];
  logic [31:0] wd[$];
  logic [3:0] wb[$];
  logic wl[$], we[$];
  int cyc = 0, errors = 0, checks = 0;
  logic pop_n = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic refresh();
    i_fifo_empty = fq.size() == 0;
    i_fifo_data  = fq.size() != 0 ? fq[0] : 8'h00;
  endtask
  // FIFO model: pop decision sampled at negedge, applied just after the posedge
  always @(negedge clk_rd) begin
    pop_n = o_fifo_rd_en;
    if (o_fifo_rd_en && i_fifo_empty) chk("rd_en_while_empty", 1, 0);
    if (o_valid && i_ready) begin
      wd.push_back(o_data);
      wb.push_back(o_be);
      wl.push_back(o_last);
      we.push_back(o_err);
    end
  end
  always @(posedge clk_rd) begin
    cyc++;
    #1;
    if (pop_n && fq.size() != 0) begin
      void'(fq.pop_front());
      pop_cyc.push_back(cyc);
    end
    refresh();
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_rd);
      #2;
    end
  endtask
  task automatic push(input int n, input logic [71:0] v);
    for (int i = 0; i < n; i++) fq.push_back(v[8*(n-1-i)+:8]);
    refresh();
  endtask
  task automatic clear_logs();
    wd.delete(); wb.delete(); wl.delete(); we.delete(); pop_cyc.delete();
  endtask
  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (wd.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("word_count", wd.size(), n);
  endtask
  initial begin
    refresh();
    tick(3);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_be", o_be, 0);
    chk("rst_last", o_last, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rd_en", o_fifo_rd_en, 0);
    rst_rd_n = 1'b1;
    i_ready = 1'b1;
    tick();
    clear_logs();
    push(6, 72'h05_11_22_33_44_55);
    wait_words(2, 20);
    chk("t1_w0_data", wd[0], 32'h44332211);
    chk("t1_w0_be", wb[0], 4'hF);
    chk("t1_w0_last", wl[0], 0);
    chk("t1_w1_data", wd[1], 32'h00000055);
    chk("t1_w1_be", wb[1], 4'h1);
    chk("t1_w1_last", wl[1], 1);
    chk("t1_pops", pop_cyc.size(), 6);
    chk("t1_pop_span", pop_cyc[5] - pop_cyc[0], 5);
    clear_logs();
    push(5, 72'h00_00_02_AA_BB);
    wait_words(1, 20);
    tick(3);
    chk("t2_words", wd.size(), 1);
    chk("t2_data", wd[0], 32'h0000BBAA);
    chk("t2_be", wb[0], 4'h3);
    chk("t2_last", wl[0], 1);
    chk("t2_pops", pop_cyc.size(), 5);
    clear_logs();
    i_ready = 1'b0;
    push(9, 72'h08_01_02_03_04_05_06_07_08);
    tick(6);
    chk("t3_hold_early", o_data, 32'h04030201);
    tick(6);
    chk("t3_valid", o_valid, 1);
    chk("t3_hold_data", o_data, 32'h04030201);
    chk("t3_hold_be", o_be, 4'hF);
    chk("t3_hold_last", o_last, 0);
    chk("t3_stall_rd_en", o_fifo_rd_en, 0);
    chk("t3_fifo_left", fq.size(), 1);
    chk("t3_pops", pop_cyc.size(), 8);
    i_ready = 1'b1;
    tick();
    chk("t3_cont_valid", o_valid, 1);
    chk("t3_w1_data", o_data, 32'h08070605);
    chk("t3_w1_be", o_be, 4'hF);
    chk("t3_w1_last", o_last, 1);
    chk("t3_fifo_drained", fq.size(), 0);
    tick();
    chk("t3_valid_drop", o_valid, 0);
    chk("t3_words", wd.size(), 2);
    clear_logs();
    push(4, 72'h01_7E_01_7F);
    wait_words(2, 20);
    chk("t4_w0_data", wd[0], 32'h0000007E);
    chk("t4_w0_be", wb[0], 4'h1);
    chk("t4_w0_last", wl[0], 1);
    chk("t4_w1_data", wd[1], 32'h0000007F);
    chk("t4_w1_last", wl[1], 1);
    chk("t4_pops", pop_cyc.size(), 4);
    chk("t4_pop_span", pop_cyc[3] - pop_cyc[0], 3);
    clear_logs();
    i_ready = 1'b0;
    push(6, 72'h05_11_22_33_44_55);
    tick(8);
    chk("t5_pre_valid", o_valid, 1);
    rst_rd_n = 1'b0;
    fq.delete();
    refresh();
    #1;
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_data", o_data, 0);
    chk("t5_rst_be", o_be, 0);
    chk("t5_rst_last", o_last, 0);
    tick();
    rst_rd_n = 1'b1;
    i_ready = 1'b1;
    tick();
    clear_logs();
    push(2, 72'h01_5A);
    wait_words(1, 20);
    chk("t5_data", wd[0], 32'h0000005A);
    chk("t5_be", wb[0], 4'h1);
    chk("t5_last", wl[0], 1);
    chk("t5_err", we[0], 0);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    clear_logs();
    push(3, 72'h06_01_02);
    wait_words(1, 30);
    chk("t6_data", wd[0], 32'h00000201);
    chk("t6_be", wb[0], 4'h3);
    chk("t6_last", wl[0], 1);
    chk("t6_err", we[0], 1);
    clear_logs();
    push(2, 72'h01_33);
    wait_words(1, 20);
    chk("t6_after_data", wd[0], 32'h00000033);
    chk("t6_after_err", we[0], 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
